// File: rtl/inst_queue.sv
// Instruction FIFO ahead of the control unit; a push is visible on inst_o the cycle after it is accepted.
// Backpressure: host_ready_o drops when full, flushing or in reset. Full blocks a push even when a pop happens.
package inst_queue_pkg;
  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } instruction_t;
endpackage

module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  instruction_t       host_inst_i,
  input  logic               host_valid_i,
  output logic               host_ready_o,
  output instruction_t       inst_o,
  output logic               inst_valid_o,
  input  logic               inst_ready_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output logic               full_o
);

  localparam int PTR_W = $clog2(DEPTH);

  instruction_t           mem [DEPTH];
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W-1:0]       wr_ptr;
  logic [CNT_W-1:0]       count;
  logic                   push;
  logic                   pop;

  assign empty_o      = (count == '0);
  assign full_o       = (count == CNT_W'(DEPTH));
  assign count_o      = count;
  assign host_ready_o = !full_o && !flush_i && rst_i;
  // Valid is masked by reset so stale entries never reach control while reset is held.
  assign inst_valid_o = !empty_o && rst_i;
  assign inst_o       = mem[rd_ptr];

  assign push = host_valid_i && host_ready_o;
  assign pop  = inst_valid_o && inst_ready_i;

  // Storage carries no reset; push is already blocked during reset and flush.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= host_inst_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i || flush_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: a queue-based reference model is checked every cycle, plus directed scenarios with literal expectations.
module tb_inst_queue;
  import inst_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic               flush;
  instruction_t       host_inst;
  logic               host_valid;
  logic               host_ready;
  instruction_t       inst;
  logic               inst_valid;
  logic               inst_ready;
  logic [CNT_W-1:0]   count;
  logic               empty;
  logic               full;

  int           checks = 0;
  int           errors = 0;
  bit           started = 1'b0;
  instruction_t model_q[$];
  instruction_t got[$];

  always #5 clk = ~clk;

  inst_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .flush_i      (flush),
    .host_inst_i  (host_inst),
    .host_valid_i (host_valid),
    .host_ready_o (host_ready),
    .inst_o       (inst),
    .inst_valid_o (inst_valid),
    .inst_ready_i (inst_ready),
    .count_o      (count),
    .empty_o      (empty),
    .full_o       (full)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_got(input string name, input int n, input logic [31:0] first);
    chk({name, "_len"}, 32'(got.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      chk(name, (i < got.size()) ? 32'(got[i]) : 32'hxxxx_xxxx, first + 32'(i));
    end
  endtask

  // Model checked at the falling edge, then advanced to the state after the next rising edge.
  always @(negedge clk) begin
    bit exp_rdy;
    bit exp_vld;
    exp_rdy = rst && !flush && (model_q.size() < DEPTH);
    exp_vld = rst && (model_q.size() > 0);
    if (started) begin
      chk("cmp_count", 32'(count), 32'(model_q.size()));
      chk("cmp_empty", 32'(empty), 32'(model_q.size() == 0));
      chk("cmp_full", 32'(full), 32'(model_q.size() == DEPTH));
      chk("cmp_valid", 32'(inst_valid), 32'(exp_vld));
      chk("cmp_ready", 32'(host_ready), 32'(exp_rdy));
      if (exp_vld) chk("cmp_inst", 32'(inst), 32'(model_q[0]));
    end
    if (inst_valid === 1'b1 && inst_ready) got.push_back(inst);
    if (!rst || flush) begin
      model_q.delete();
    end else begin
      if (exp_vld && inst_ready) void'(model_q.pop_front());
      if (host_valid && exp_rdy) model_q.push_back(host_inst);
    end
  end

  initial begin
    rst = 1'b0; flush = 1'b0; host_valid = 1'b0; inst_ready = 1'b0; host_inst = '0;
    step();
    started = 1'b1;
    step();
    step();
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_ready", 32'(host_ready), 32'd0);
    rst = 1'b1;
    #1;
    chk("rel_ready", 32'(host_ready), 32'd1);

    // Fill to full, offer a 9th while full, then drain in order.
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      host_valid = 1'b1; host_inst = instruction_t'(32'(i));
      step();
    end
    host_inst = instruction_t'(32'h9);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd8);
    chk("fill_ready", 32'(host_ready), 32'd0);
    inst_ready = 1'b1;
    step();
    chk("fullpop_count", 32'(count), 32'd7);
    chk("fullpop_ready", 32'(host_ready), 32'd1);
    step();
    host_valid = 1'b0;
    chk("fullpop_accept_count", 32'(count), 32'd7);
    for (int i = 0; i < 20 && empty !== 1'b1; i++) step();
    chk("drain_empty", 32'(empty), 32'd1);
    chk_got("drain_order", 9, 32'h1);

    // Streaming across pointer wraps.
    got.delete();
    for (int i = 0; i < 20; i++) begin
      host_valid = 1'b1; host_inst = instruction_t'(32'h10 + 32'(i));
      step();
      chk("stream_count", 32'(count), 32'd1);
    end
    host_valid = 1'b0;
    step();
    chk("stream_end_count", 32'(count), 32'd0);
    chk_got("stream_order", 20, 32'h10);

    // Head must hold still under control backpressure.
    got.delete();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      host_valid = 1'b1; host_inst = instruction_t'(32'h31 + 32'(i));
      step();
    end
    host_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_inst", 32'(inst), 32'h31);
      chk("stall_valid", 32'(inst_valid), 32'd1);
    end
    chk("stall_count", 32'(count), 32'd3);
    inst_ready = 1'b1;
    step(); step(); step();
    inst_ready = 1'b0;
    chk("stall_empty", 32'(empty), 32'd1);
    chk_got("stall_order", 3, 32'h31);

    // Flush with a concurrent push and pop.
    got.delete();
    for (int i = 0; i < 5; i++) begin
      host_valid = 1'b1; host_inst = instruction_t'(32'h41 + 32'(i));
      step();
    end
    chk("flush_pre_count", 32'(count), 32'd5);
    flush = 1'b1; host_inst = instruction_t'(32'h46); inst_ready = 1'b1;
    #1;
    chk("flush_ready", 32'(host_ready), 32'd0);
    step();
    flush = 1'b0; host_valid = 1'b0; inst_ready = 1'b0;
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid", 32'(inst_valid), 32'd0);
    host_valid = 1'b1; host_inst = instruction_t'(32'hAA);
    step();
    host_valid = 1'b0;
    chk("post_flush_inst", 32'(inst), 32'hAA);
    chk("post_flush_count", 32'(count), 32'd1);
    inst_ready = 1'b1;
    step();
    inst_ready = 1'b0;
    chk("post_flush_len", 32'(got.size()), 32'd2);
    chk("flush_consumed", (got.size() > 0) ? 32'(got[0]) : 32'hxxxx_xxxx, 32'h41);
    chk("flush_next", (got.size() > 1) ? 32'(got[1]) : 32'hxxxx_xxxx, 32'hAA);

    // Reset in the middle of traffic.
    got.delete();
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1; host_inst = instruction_t'(32'h51 + 32'(i));
      step();
    end
    host_valid = 1'b0;
    chk("mid_pre_count", 32'(count), 32'd4);
    rst = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(inst_valid), 32'd0);
    chk("mid_rst_ready", 32'(host_ready), 32'd0);
    step();
    chk("mid_rst_valid2", 32'(inst_valid), 32'd0);
    chk("mid_rst_ready2", 32'(host_ready), 32'd0);
    step();
    rst = 1'b1; inst_ready = 1'b1;
    #1;
    chk("mid_rel_count", 32'(count), 32'd0);
    chk("mid_rel_ready", 32'(host_ready), 32'd1);
    chk("mid_rel_valid", 32'(inst_valid), 32'd0);
    step(); step();
    chk("mid_no_stale", 32'(got.size()), 32'd0);
    host_valid = 1'b1; host_inst = instruction_t'(32'h61);
    step();
    host_valid = 1'b0;
    chk("mid_first_inst", 32'(inst), 32'h61);
    chk("mid_first_valid", 32'(inst_valid), 32'd1);
    step();
    chk("mid_end_empty", 32'(empty), 32'd1);
    chk_got("mid_order", 1, 32'h61);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
